// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: op encodings and pipeline depth.
package shifter_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    // Number of register stages: one after every reg_every mux levels, last level always registered.
    function automatic int unsigned calc_nreg(input int unsigned width, input int unsigned reg_every);
        int unsigned levels;
        levels = $clog2(width);
        return (levels + reg_every - 1) / reg_every;
    endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational mux level of the barrel shifter, shifting by DIST when enabled.
// With PIPELINED_SHIFTER_STICKY_EN defined it also reports the OR of the bits it discards.
module shift_level
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIST  = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    input  logic [1:0]       op,
`ifdef PIPELINED_SHIFTER_STICKY_EN
    output logic             sticky,
`endif
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = data;
        if (en) begin
            case (op)
                OP_SLL:  result = data << DIST;
                OP_SRL:  result = data >> DIST;
                OP_SRA:  result = WIDTH'($signed(data) >>> DIST);
                default: result = (data >> DIST) | (data << (WIDTH - DIST));
            endcase
        end
    end

`ifdef PIPELINED_SHIFTER_STICKY_EN
    // Rotation loses nothing; logical/arithmetic shifts drop the bits pushed off the edge.
    always_comb begin
        sticky = 1'b0;
        if (en) begin
            case (op)
                OP_SLL:         sticky = |data[WIDTH-1 -: DIST];
                OP_SRL, OP_SRA: sticky = |data[DIST-1:0];
                default:        sticky = 1'b0;
            endcase
        end
    end
`endif

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready, bubble collapse, flush and tag sideband.
// Optional out_sticky (OR of shifted-out bits) is enabled by defining PIPELINED_SHIFTER_STICKY_EN.
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned REG_EVERY = 2,
    parameter int unsigned TAG_W     = 5
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_amt,
    input  logic [1:0]               in_op,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
`ifdef PIPELINED_SHIFTER_STICKY_EN
    output logic                     out_sticky,
`endif
    output logic [WIDTH-1:0]         out_data,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int unsigned LEVELS = $clog2(WIDTH);
    localparam int unsigned NREG   = calc_nreg(WIDTH, REG_EVERY);

    logic [NREG-1:0]   valid_q;
    logic [NREG-1:0]   ready;
    logic [NREG-1:0]   src_valid;
    logic [WIDTH-1:0]  data_q   [NREG];
    logic [LEVELS-1:0] amt_q    [NREG];
    logic [1:0]        op_q     [NREG];
    logic [TAG_W-1:0]  tag_q    [NREG];
    logic [WIDTH-1:0]  src_data [NREG];
    logic [LEVELS-1:0] src_amt  [NREG];
    logic [1:0]        src_op   [NREG];
    logic [TAG_W-1:0]  src_tag  [NREG];
    logic [WIDTH-1:0]  stg_data [NREG];
    logic [LEVELS-1:0] stg_amt  [NREG];
`ifdef PIPELINED_SHIFTER_STICKY_EN
    logic [NREG-1:0]   sticky_q;
    logic [NREG-1:0]   src_sticky;
    logic [NREG-1:0]   stg_sticky;
`endif

    // Backward ready chain, evaluated from the output stage toward the input.
    always_comb begin : p_ready
        logic [NREG:0] rdy;
        rdy       = '0;
        rdy[NREG] = out_ready;
        for (int k = int'(NREG) - 1; k >= 0; k--) begin
            rdy[k] = !valid_q[k] || rdy[k+1];
        end
        ready = rdy[NREG-1:0];
    end

    assign in_ready = ready[0] && reset_n && !flush;

    for (genvar s = 0; s < NREG; s++) begin : g_stage
        localparam int unsigned FIRST = s * REG_EVERY;
        localparam int unsigned LAST  = (FIRST + REG_EVERY <= LEVELS) ? FIRST + REG_EVERY - 1 : LEVELS - 1;

        if (s == 0) begin : g_head
            assign src_valid[s] = in_valid;
            assign src_data[s]  = in_data;
            assign src_amt[s]   = in_amt;
            assign src_op[s]    = in_op;
            assign src_tag[s]   = in_tag;
`ifdef PIPELINED_SHIFTER_STICKY_EN
            assign src_sticky[s] = 1'b0;
`endif
        end else begin : g_body
            assign src_valid[s] = valid_q[s-1];
            assign src_data[s]  = data_q[s-1];
            assign src_amt[s]   = amt_q[s-1];
            assign src_op[s]    = op_q[s-1];
            assign src_tag[s]   = tag_q[s-1];
`ifdef PIPELINED_SHIFTER_STICKY_EN
            assign src_sticky[s] = sticky_q[s-1];
`endif
        end

        // The amount is shifted down one bit per level so each level always reads bit 0.
        for (genvar l = FIRST; l <= LAST; l++) begin : g_level
            logic [WIDTH-1:0]  din;
            logic [WIDTH-1:0]  dout;
            logic [LEVELS-1:0] ain;
            logic [LEVELS-1:0] aout;
`ifdef PIPELINED_SHIFTER_STICKY_EN
            logic              sin;
            logic              sout;
            logic              scontrib;
`endif
            if (l == FIRST) begin : g_src
                assign din = src_data[s];
                assign ain = src_amt[s];
`ifdef PIPELINED_SHIFTER_STICKY_EN
                assign sin = src_sticky[s];
`endif
            end else begin : g_chain
                assign din = g_level[l-1].dout;
                assign ain = g_level[l-1].aout;
`ifdef PIPELINED_SHIFTER_STICKY_EN
                assign sin = g_level[l-1].sout;
`endif
            end

            assign aout = ain >> 1;

            shift_level #(
                .WIDTH (WIDTH),
                .DIST  (32'(1 << l))
            ) u_level (
                .data   (din),
                .en     (ain[0]),
                .op     (src_op[s]),
`ifdef PIPELINED_SHIFTER_STICKY_EN
                .sticky (scontrib),
`endif
                .result (dout)
            );

`ifdef PIPELINED_SHIFTER_STICKY_EN
            assign sout = sin | scontrib;
`endif
        end

        assign stg_data[s] = g_level[LAST].dout;
        assign stg_amt[s]  = g_level[LAST].aout;
`ifdef PIPELINED_SHIFTER_STICKY_EN
        assign stg_sticky[s] = g_level[LAST].sout;
`endif
    end

    // Valid bits: a stage takes the upstream valid whenever it is ready, collapsing bubbles.
    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            valid_q <= '0;
        end else begin
            for (int s = 0; s < int'(NREG); s++) begin
                if (ready[s]) begin
                    valid_q[s] <= src_valid[s];
                end
            end
        end
    end

    // Payload registers; only the output stage is reset.
    always_ff @(posedge clock) begin
        for (int s = 0; s < int'(NREG); s++) begin
            if (ready[s] && src_valid[s]) begin
                data_q[s] <= stg_data[s];
                amt_q[s]  <= stg_amt[s];
                op_q[s]   <= src_op[s];
                tag_q[s]  <= src_tag[s];
`ifdef PIPELINED_SHIFTER_STICKY_EN
                sticky_q[s] <= stg_sticky[s];
`endif
            end
        end
        if (!reset_n) begin
            data_q[NREG-1] <= '0;
            tag_q[NREG-1]  <= '0;
`ifdef PIPELINED_SHIFTER_STICKY_EN
            sticky_q[NREG-1] <= 1'b0;
`endif
        end
    end

    assign out_valid = valid_q[NREG-1];
    assign out_data  = data_q[NREG-1];
    assign out_tag   = tag_q[NREG-1];
`ifdef PIPELINED_SHIFTER_STICKY_EN
    assign out_sticky = sticky_q[NREG-1];
`endif

endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed self-checking bench for pipelined_shifter at WIDTH=32, REG_EVERY=2 (three stages).
module tb_pipelined_shifter;
    import shifter_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_amt;
    logic [1:0]  in_op;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
`ifdef PIPELINED_SHIFTER_STICKY_EN
    logic        out_sticky;
`endif

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    pipelined_shifter #(
        .WIDTH     (32),
        .REG_EVERY (2),
        .TAG_W     (5)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef PIPELINED_SHIFTER_STICKY_EN
        .out_sticky(out_sticky),
`endif
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Drive a pass-through op (SLL by 0) whose data is derived from its tag.
    task automatic present(input int k);
        in_valid = 1'b1;
        in_data  = 32'h1111_1111 * 32'(k);
        in_amt   = 5'd0;
        in_op    = OP_SLL;
        in_tag   = 5'(k);
    endtask

    task automatic run_op(input string name, input logic [31:0] d, input logic [4:0] a,
                          input logic [1:0] op, input logic [4:0] tag, input logic [31:0] exp);
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        in_op    = op;
        in_tag   = tag;
        #1;
        chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk({name, "_lat1"}, 32'(out_valid), 32'd0);
        tick();
        chk({name, "_lat2"}, 32'(out_valid), 32'd0);
        tick();
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_data"}, out_data, exp);
        chk({name, "_tag"}, 32'(out_tag), 32'(tag));
        tick();
        chk({name, "_drained"}, 32'(out_valid), 32'd0);
    endtask

`ifdef PIPELINED_SHIFTER_STICKY_EN
    task automatic run_sticky(input string name, input logic [31:0] d, input logic [4:0] a,
                              input logic [1:0] op, input logic exp_st);
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        in_op    = op;
        in_tag   = 5'd3;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_sticky"}, 32'(out_sticky), 32'(exp_st));
        tick();
    endtask
`endif

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_op     = OP_SLL;
        in_tag    = '0;
        out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_in_ready_low", 32'(in_ready), 32'd0);
        reset_n = 1'b1;
        #1;
        chk("rst_in_ready_release", 32'(in_ready), 32'd1);
        tick();

        // Modes
        out_ready = 1'b1;
        run_op("sra31", 32'h8000_0000, 5'd31, OP_SRA, 5'd7, 32'hFFFF_FFFF);
        run_op("srl31", 32'h8000_0000, 5'd31, OP_SRL, 5'd8, 32'h0000_0001);
        run_op("sll31", 32'h0000_0001, 5'd31, OP_SLL, 5'd9, 32'h8000_0000);
        run_op("ror1", 32'h0000_0001, 5'd1, OP_ROR, 5'd10, 32'h8000_0000);
        run_op("ror8", 32'h1234_5678, 5'd8, OP_ROR, 5'd11, 32'h7812_3456);
        run_op("sll0", 32'hDEAD_BEEF, 5'd0, OP_SLL, 5'd12, 32'hDEAD_BEEF);
        run_op("srl0", 32'hDEAD_BEEF, 5'd0, OP_SRL, 5'd13, 32'hDEAD_BEEF);
        run_op("sra0", 32'hDEAD_BEEF, 5'd0, OP_SRA, 5'd14, 32'hDEAD_BEEF);
        run_op("ror0", 32'hDEAD_BEEF, 5'd0, OP_ROR, 5'd15, 32'hDEAD_BEEF);
        run_op("sra4", 32'h8F00_0000, 5'd4, OP_SRA, 5'd16, 32'hF8F0_0000);

        // Backpressure: three accepts fill the pipe
        out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            present(k);
            #1;
            chk("bp_accept", 32'(in_ready), 32'd1);
            tick();
        end
        present(4);
        #1;
        chk("bp_full_in_ready", 32'(in_ready), 32'd0);
        chk("bp_full_valid", 32'(out_valid), 32'd1);
        chk("bp_full_tag", 32'(out_tag), 32'd1);
        tick();
        tick();
        chk("bp_hold_tag", 32'(out_tag), 32'd1);
        chk("bp_hold_data", out_data, 32'h1111_1111);
        chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        tick();
        present(5);
        #1;
        chk("bp_out_tag2", 32'(out_tag), 32'd2);
        chk("bp_in_ready_tag5", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_out_tag3", 32'(out_tag), 32'd3);
        tick();
        chk("bp_out_tag4", 32'(out_tag), 32'd4);
        chk("bp_out_valid4", 32'(out_valid), 32'd1);
        tick();
        chk("bp_out_tag5", 32'(out_tag), 32'd5);
        chk("bp_out_data5", out_data, 32'h5555_5555);
        tick();
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Bubble collapse: ops at cycles 0 and 2, consumer stalled until cycle 10
        out_ready = 1'b0;
        present(10);
        tick();
        in_valid = 1'b0;
        tick();
        present(11);
        #1;
        chk("bub_accept_b", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        for (int c = 3; c < 10; c++) begin
            chk("bub_in_ready_open", 32'(in_ready), 32'd1);
            tick();
        end
        chk("bub_out_valid", 32'(out_valid), 32'd1);
        chk("bub_out_tag", 32'(out_tag), 32'd10);
        present(12);
        #1;
        chk("bub_accept_c", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bub_full", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bub_tag10", 32'(out_tag), 32'd10);
        tick();
        chk("bub_tag11", 32'(out_tag), 32'd11);
        chk("bub_data11", out_data, 32'h1111_1111 * 32'd11);
        tick();
        chk("bub_tag12", 32'(out_tag), 32'd12);
        tick();
        chk("bub_drained", 32'(out_valid), 32'd0);

        // Flush with three ops in flight
        out_ready = 1'b0;
        for (int k = 20; k <= 22; k++) begin
            present(k);
            tick();
        end
        present(23);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("flush_no_tag", 32'(out_valid), 32'd0);
        end

        // Reset mid-stream
        present(30);
        tick();
        present(31);
        tick();
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        chk("mrst_in_ready_low", 32'(in_ready), 32'd0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_out_data", out_data, 32'd0);
        chk("mrst_out_tag", 32'(out_tag), 32'd0);
        chk("mrst_in_ready_high", 32'(in_ready), 32'd1);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("mrst_lost", 32'(out_valid), 32'd0);
        end
        run_op("mrst_new", 32'hF000_0000, 5'd4, OP_SRA, 5'd9, 32'hFF00_0000);

`ifdef PIPELINED_SHIFTER_STICKY_EN
        run_sticky("st_srl_clean", 32'h0000_0010, 5'd4, OP_SRL, 1'b0);
        run_sticky("st_srl_lost", 32'h0000_0018, 5'd4, OP_SRL, 1'b1);
        run_sticky("st_sll_lost", 32'h8000_0000, 5'd1, OP_SLL, 1'b1);
        run_sticky("st_ror", 32'h8000_0001, 5'd5, OP_ROR, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
